bus_alu_sequencer: RTL

A parametrised single-bus register-transfer datapath with a built-in control-step sequencer. It holds a general register file, a Y operand register, a Z result register and an ALU that supports add/sub/logic and variable-amount shifts and rotates. On a start request it executes Ra <- Rb op Rc autonomously over three bus cycles, replacing externally sequenced per-signal control (Rxout/Rxin/Yin/ZLowIn) for register-register ALU instructions. A side port loads and reads registers for initialisation and checking.

---
 rtl/bus_alu_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bus_alu_sequencer.sv
// Single-bus register-transfer datapath that executes Ra <- Rb op Rc over three bus cycles
// (T1: Y <= R[rb], T2: Z <= ALU(Y, R[rc]), T3: R[ra] <= Z) on a start request.
module bus_alu_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 16,
  parameter int unsigned RIDX  = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [RIDX-1:0]  ra,
  input  logic [RIDX-1:0]  rb,
  input  logic [RIDX-1:0]  rc,
  input  logic             ld_en,
  input  logic [RIDX-1:0]  ld_idx,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [RIDX-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam logic [RIDX:0] NRegsL = (RIDX+1)'(NREGS);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpShr  = 4'd4;
  localparam logic [3:0] OpShra = 4'd5;
  localparam logic [3:0] OpShl  = 4'd6;
  localparam logic [3:0] OpRor  = 4'd7;
  localparam logic [3:0] OpRol  = 4'd8;
  localparam logic [3:0] OpNeg  = 4'd9;
  localparam logic [3:0] OpNot  = 4'd10;

  typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [RIDX-1:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [WIDTH-1:0] y_q, y_d, z_q, z_d;
  logic             done_q, done_d, illegal_q, illegal_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   alu_res;
  logic [2*WIDTH-1:0] dbl;
  logic [ShW-1:0]     rot_n, rot_n_neg;

  // R0 and indices beyond the register file are neither readable nor writable.
  function automatic logic idx_ok(input logic [RIDX-1:0] idx);
    return ({1'b0, idx} < NRegsL) && (idx != '0);
  endfunction

  function automatic logic [WIDTH-1:0] reg_rd(input logic [RIDX-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    if (idx_ok(idx)) v = regs_q[idx];
    return v;
  endfunction

  always_comb begin
    bus = '0;
    unique case (state_q)
      StIdle: bus = '0;
      StT1:   bus = reg_rd(rb_q);
      StT2:   bus = reg_rd(rc_q);
      StT3:   bus = z_q;
      default: bus = '0;
    endcase
  end

  // Rotates shift a doubled copy; rotate-left by n equals rotate-right by -n mod WIDTH.
  always_comb begin
    dbl       = {y_q, y_q};
    rot_n     = bus[ShW-1:0];
    rot_n_neg = -rot_n;
    alu_res   = '0;
    unique case (op_q)
      OpAdd:   alu_res = y_q + bus;
      OpSub:   alu_res = y_q - bus;
      OpAnd:   alu_res = y_q & bus;
      OpOr:    alu_res = y_q | bus;
      OpShr:   alu_res = y_q >> bus;
      OpShra:  alu_res = $signed(y_q) >>> bus;
      OpShl:   alu_res = y_q << bus;
      OpRor:   alu_res = WIDTH'(dbl >> rot_n);
      OpRol:   alu_res = WIDTH'(dbl >> rot_n_neg);
      OpNeg:   alu_res = -bus;
      OpNot:   alu_res = ~bus;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rc_d      = rc_q;
    y_d       = y_q;
    z_d       = z_q;
    regs_d    = regs_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_en && idx_ok(ld_idx)) regs_d[ld_idx] = ld_data;
        if (start) begin
          op_d    = op;
          ra_d    = ra;
          rb_d    = rb;
          rc_d    = rc;
          state_d = StT1;
        end
      end
      StT1: begin
        y_d     = bus;
        state_d = StT2;
      end
      StT2: begin
        z_d     = alu_res;
        state_d = StT3;
      end
      StT3: begin
        if (idx_ok(ra_q)) regs_d[ra_q] = bus;
        done_d    = 1'b1;
        illegal_d = (op_q > OpNot);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StIdle;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      y_q       <= '0;
      z_q       <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      y_q       <= y_d;
      z_q       <= z_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  assign rd_data = reg_rd(rd_idx);
  assign bus_out = bus;
  assign result  = z_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule
